// File: rtl/cdb_writeback.sv
// -----------------------------------------------------------------------------
// cdb_writeback
//
// Write-back end of the execution stage. Completed results from the two
// add/sub units and the mul/div unit are queued in small per-unit FIFOs and
// then arbitrated round-robin onto the single common data bus (CDB). One
// tag/value pair is broadcast per cycle. The broadcasting unit receives a
// one-cycle free pulse so dispatch may reuse it.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   add0_valid/tag/value       result from add/sub unit 0
//   add0_ready                 add0 buffer has space (count < DEPTH)
//   add1_* , mdu_*             same, for add/sub unit 1 and the mul/div unit
//   cdb_hold                   consumers stall; no broadcast this cycle
//   cdb_valid/tag/value        registered broadcast
//   cdb_src                    broadcasting source: 0 add0, 1 add1, 2 mdu
//   add0_free/add1_free/mdu_free  one-cycle pulse aligned with cdb_valid
//   err_overflow               sticky; a result arrived while its buffer was full
// -----------------------------------------------------------------------------
module cdb_writeback #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              add0_valid,
  input  logic [TAG_W-1:0]  add0_tag,
  input  logic [DATA_W-1:0] add0_value,
  output logic              add0_ready,
  input  logic              add1_valid,
  input  logic [TAG_W-1:0]  add1_tag,
  input  logic [DATA_W-1:0] add1_value,
  output logic              add1_ready,
  input  logic              mdu_valid,
  input  logic [TAG_W-1:0]  mdu_tag,
  input  logic [DATA_W-1:0] mdu_value,
  output logic              mdu_ready,
  input  logic              cdb_hold,
  output logic              cdb_valid,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_value,
  output logic [1:0]        cdb_src,
  output logic              add0_free,
  output logic              add1_free,
  output logic              mdu_free,
  output logic              err_overflow
);

  localparam int NSRC  = 3;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Round-robin successor over the three sources; encoding 3 is never produced.
  function automatic logic [1:0] next_src(input logic [1:0] s);
    return (s == 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

  logic [NSRC-1:0]   src_valid;
  logic [NSRC-1:0]   src_ready;
  logic [NSRC-1:0]   nonempty;
  logic [NSRC-1:0]   push;
  logic [NSRC-1:0]   pop;
  logic [TAG_W-1:0]  src_tag   [NSRC];
  logic [DATA_W-1:0] src_value [NSRC];

  logic [TAG_W-1:0]  tag_mem [NSRC][DEPTH];
  logic [DATA_W-1:0] val_mem [NSRC][DEPTH];
  logic [PTR_W-1:0]  wr_ptr  [NSRC];
  logic [PTR_W-1:0]  rd_ptr  [NSRC];
  logic [CNT_W-1:0]  count   [NSRC];

  logic              grant_vld;
  logic [1:0]        grant_idx;
  logic [1:0]        cand;
  logic [3:0]        nonempty_x;
  logic [TAG_W-1:0]  head_tag;
  logic [DATA_W-1:0] head_value;

  logic [1:0]        rr_p0;
  logic              cdb_vld_p1;
  logic [TAG_W-1:0]  cdb_tag_p1;
  logic [DATA_W-1:0] cdb_value_p1;
  logic [1:0]        cdb_src_p1;
  logic [NSRC-1:0]   free_p1;
  logic              err_p1;

  assign src_valid    = {mdu_valid, add1_valid, add0_valid};
  assign src_tag[0]   = add0_tag;
  assign src_tag[1]   = add1_tag;
  assign src_tag[2]   = mdu_tag;
  assign src_value[0] = add0_value;
  assign src_value[1] = add1_value;
  assign src_value[2] = mdu_value;

  // Ready comes from the registered count only, so a full buffer never
  // accepts even if it is being popped in the same cycle.
  always_comb begin
    src_ready = '0;
    nonempty  = '0;
    for (int i = 0; i < NSRC; i++) begin
      src_ready[i] = (count[i] < CNT_W'(DEPTH));
      nonempty[i]  = (count[i] != '0);
    end
  end

  assign push       = src_valid & src_ready;
  assign nonempty_x = {1'b0, nonempty};

  // First non-empty buffer at or after the round-robin pointer.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 2'd0;
    cand      = rr_p0;
    for (int k = 0; k < NSRC; k++) begin
      if (!grant_vld && nonempty_x[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
      cand = next_src(cand);
    end
  end

  assign pop = (grant_vld && !cdb_hold) ? (3'b001 << grant_idx) : 3'b000;

  always_comb begin
    head_tag   = '0;
    head_value = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (grant_idx == 2'(i)) begin
        head_tag   = tag_mem[i][rd_ptr[i]];
        head_value = val_mem[i][rd_ptr[i]];
      end
    end
  end

  // ---- stage p0: per-source buffer control ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NSRC; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + CNT_W'(1);
          2'b01:   count[i] <= count[i] - CNT_W'(1);
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  // Buffer storage carries no reset; emptiness is tracked by count alone.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NSRC; i++) begin
      if (push[i]) begin
        tag_mem[i][wr_ptr[i]] <= src_tag[i];
        val_mem[i][wr_ptr[i]] <= src_value[i];
      end
    end
  end

  // ---- stage p1: CDB broadcast register ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_p0        <= 2'd0;
      cdb_vld_p1   <= 1'b0;
      cdb_tag_p1   <= '0;
      cdb_value_p1 <= '0;
      cdb_src_p1   <= 2'd0;
      free_p1      <= '0;
      err_p1       <= 1'b0;
    end else begin
      err_p1 <= err_p1 | (|(src_valid & ~src_ready));
      if (grant_vld && !cdb_hold) begin
        cdb_vld_p1   <= 1'b1;
        cdb_tag_p1   <= head_tag;
        cdb_value_p1 <= head_value;
        cdb_src_p1   <= grant_idx;
        free_p1      <= pop;
        rr_p0        <= next_src(grant_idx);
      end else begin
        // Tag/value/src keep their last broadcast values.
        cdb_vld_p1 <= 1'b0;
        free_p1    <= '0;
      end
    end
  end

  assign add0_ready   = src_ready[0];
  assign add1_ready   = src_ready[1];
  assign mdu_ready    = src_ready[2];
  assign cdb_valid    = cdb_vld_p1;
  assign cdb_tag      = cdb_tag_p1;
  assign cdb_value    = cdb_value_p1;
  assign cdb_src      = cdb_src_p1;
  assign add0_free    = free_p1[0];
  assign add1_free    = free_p1[1];
  assign mdu_free     = free_p1[2];
  assign err_overflow = err_p1;

endmodule

// File: tb/tb_cdb_writeback.sv
// -----------------------------------------------------------------------------
// tb_cdb_writeback
//
// Self-checking bench for cdb_writeback. A queue-based reference model tracks
// each source's pending results, the round-robin pointer and the expected CDB
// outputs; scenario tasks add directed checks on top of the model comparison.
// -----------------------------------------------------------------------------
module tb_cdb_writeback;

  localparam int DATA_W = 32;
  localparam int TAG_W  = 4;
  localparam int DEPTH  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              add0_valid, add1_valid, mdu_valid;
  logic [TAG_W-1:0]  add0_tag, add1_tag, mdu_tag;
  logic [DATA_W-1:0] add0_value, add1_value, mdu_value;
  logic              add0_ready, add1_ready, mdu_ready;
  logic              cdb_hold;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_value;
  logic [1:0]        cdb_src;
  logic              add0_free, add1_free, mdu_free;
  logic              err_overflow;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [35:0]       q [3][$];
  int                rr;
  logic              e_valid;
  logic [TAG_W-1:0]  e_tag;
  logic [DATA_W-1:0] e_value;
  logic [1:0]        e_src;
  logic [2:0]        e_free;
  logic              e_err;

  cdb_writeback #(.DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .add0_valid(add0_valid), .add0_tag(add0_tag), .add0_value(add0_value), .add0_ready(add0_ready),
    .add1_valid(add1_valid), .add1_tag(add1_tag), .add1_value(add1_value), .add1_ready(add1_ready),
    .mdu_valid(mdu_valid), .mdu_tag(mdu_tag), .mdu_value(mdu_value), .mdu_ready(mdu_ready),
    .cdb_hold(cdb_hold),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value), .cdb_src(cdb_src),
    .add0_free(add0_free), .add1_free(add1_free), .mdu_free(mdu_free),
    .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [45:0] obs_vec();
    return {cdb_valid, cdb_tag, cdb_value, cdb_src, mdu_free, add1_free, add0_free,
            mdu_ready, add1_ready, add0_ready, err_overflow};
  endfunction

  function automatic logic [45:0] exp_vec();
    logic [2:0] r;
    for (int i = 0; i < 3; i++) r[i] = (q[i].size() < DEPTH);
    return {e_valid, e_tag, e_value, e_src, e_free, r, e_err};
  endfunction

  task automatic idle_inputs();
    add0_valid = 1'b0; add1_valid = 1'b0; mdu_valid = 1'b0;
    add0_tag = '0; add1_tag = '0; mdu_tag = '0;
    add0_value = '0; add1_value = '0; mdu_value = '0;
  endtask

  // Advance one clock and apply the specification's rules to the model.
  task automatic tick();
    bit               rdy [3];
    bit               vin [3];
    logic [35:0]      din [3];
    logic [35:0]      item;
    int               g;
    @(posedge clk);
    vin[0] = add0_valid; vin[1] = add1_valid; vin[2] = mdu_valid;
    din[0] = {add0_tag, add0_value};
    din[1] = {add1_tag, add1_value};
    din[2] = {mdu_tag, mdu_value};
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) q[i].delete();
      rr = 0; e_valid = 0; e_tag = '0; e_value = '0; e_src = 2'd0; e_free = '0; e_err = 0;
    end else begin
      for (int i = 0; i < 3; i++) rdy[i] = (q[i].size() < DEPTH);
      g = -1;
      if (!cdb_hold)
        for (int k = 0; k < 3; k++)
          if (g < 0 && q[(rr + k) % 3].size() > 0) g = (rr + k) % 3;
      e_free = '0;
      if (g >= 0) begin
        item      = q[g].pop_front();
        e_valid   = 1'b1;
        e_tag     = item[35:32];
        e_value   = item[31:0];
        e_src     = 2'(g);
        e_free[g] = 1'b1;
        rr        = (g + 1) % 3;
      end else begin
        e_valid = 1'b0;
      end
      for (int i = 0; i < 3; i++)
        if (vin[i]) begin
          if (rdy[i]) q[i].push_back(din[i]);
          else        e_err = 1'b1;
        end
    end
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    cdb_hold = 1'b0;
    rst_n    = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    idle_inputs();
    cdb_hold = 1'b0;
    do_reset();
    checks++;
    if (obs_vec() !== {1'b0, 4'h0, 32'h0, 2'd0, 3'b000, 3'b111, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got %h want %h", obs_vec(), {1'b0, 4'h0, 32'h0, 2'd0, 3'b000, 3'b111, 1'b0});
    end
  endtask

  task automatic test_single();
    do_reset();
    add0_valid = 1'b1; add0_tag = 4'h3; add0_value = 32'd10;
    tick();
    idle_inputs();
    checks++;
    if (cdb_valid !== 1'b0) begin
      errors++; $display("FAIL single_e1 cdb_valid got %b want 0", cdb_valid);
    end
    tick();
    checks++;
    if ({cdb_valid, cdb_tag, cdb_value, cdb_src, add0_free} !== {1'b1, 4'h3, 32'd10, 2'd0, 1'b1}) begin
      errors++;
      $display("FAIL single_e2 got v=%b t=%h d=%0d s=%0d f=%b want v=1 t=3 d=10 s=0 f=1",
               cdb_valid, cdb_tag, cdb_value, cdb_src, add0_free);
    end
    tick();
    checks++;
    if ({cdb_valid, add0_free} !== 2'b00) begin
      errors++; $display("FAIL single_e3 got v=%b f=%b want 0 0", cdb_valid, add0_free);
    end
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL single_model got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_three_sources();
    logic [3:0] want_tag [3];
    want_tag[0] = 4'd1; want_tag[1] = 4'd2; want_tag[2] = 4'd3;
    do_reset();
    add0_valid = 1'b1; add0_tag = 4'd1; add0_value = 32'd5;
    add1_valid = 1'b1; add1_tag = 4'd2; add1_value = 32'd7;
    mdu_valid  = 1'b1; mdu_tag  = 4'd3; mdu_value  = 32'd35;
    tick();
    idle_inputs();
    for (int n = 0; n < 3; n++) begin
      tick();
      checks++;
      if ({cdb_valid, cdb_tag, cdb_src, mdu_free, add1_free, add0_free} !==
          {1'b1, want_tag[n], 2'(n), 3'b001 << n}) begin
        errors++;
        $display("FAIL three_src_%0d got v=%b t=%0d s=%0d f=%b%b%b want t=%0d s=%0d",
                 n, cdb_valid, cdb_tag, cdb_src, mdu_free, add1_free, add0_free, want_tag[n], n);
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL three_src_model_%0d got %h want %h", n, obs_vec(), exp_vec());
      end
    end
    tick();
    checks++;
    if (cdb_valid !== 1'b0) begin
      errors++; $display("FAIL three_src_idle cdb_valid got %b want 0", cdb_valid);
    end
  endtask

  task automatic test_hold_overflow();
    do_reset();
    cdb_hold = 1'b1;
    mdu_valid = 1'b1; mdu_tag = 4'd8; mdu_value = 32'd80;
    tick();
    mdu_tag = 4'd9; mdu_value = 32'd90;
    tick();
    checks++;
    if ({mdu_ready, cdb_valid, err_overflow} !== 3'b000) begin
      errors++;
      $display("FAIL hold_full got rdy=%b v=%b err=%b want 0 0 0", mdu_ready, cdb_valid, err_overflow);
    end
    mdu_tag = 4'd10; mdu_value = 32'd100;
    tick();
    checks++;
    if ({err_overflow, mdu_ready} !== 2'b10) begin
      errors++; $display("FAIL hold_overflow got err=%b rdy=%b want 1 0", err_overflow, mdu_ready);
    end
    idle_inputs();
    cdb_hold = 1'b0;
    tick();
    checks++;
    if ({cdb_valid, cdb_tag, cdb_src, mdu_free, mdu_ready} !== {1'b1, 4'd8, 2'd2, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL hold_release1 got v=%b t=%0d s=%0d f=%b rdy=%b want 1 8 2 1 1",
               cdb_valid, cdb_tag, cdb_src, mdu_free, mdu_ready);
    end
    tick();
    checks++;
    if ({cdb_valid, cdb_tag, cdb_value} !== {1'b1, 4'd9, 32'd90}) begin
      errors++; $display("FAIL hold_release2 got v=%b t=%0d d=%0d want 1 9 90", cdb_valid, cdb_tag, cdb_value);
    end
    tick();
    checks++;
    if ({cdb_valid, err_overflow} !== 2'b01) begin
      errors++; $display("FAIL hold_drop got v=%b err=%b want 0 1", cdb_valid, err_overflow);
    end
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL hold_model got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_rr_skip();
    do_reset();
    add0_valid = 1'b1; add0_tag = 4'd1; add0_value = 32'd100;
    tick();
    add0_tag = 4'd5; add0_value = 32'd500;
    mdu_valid = 1'b1; mdu_tag = 4'd6; mdu_value = 32'd600;
    tick();
    idle_inputs();
    checks++;
    if ({cdb_valid, cdb_tag, cdb_src} !== {1'b1, 4'd1, 2'd0}) begin
      errors++; $display("FAIL rr_first got v=%b t=%0d s=%0d want 1 1 0", cdb_valid, cdb_tag, cdb_src);
    end
    tick();
    checks++;
    if ({cdb_valid, cdb_tag, cdb_src, mdu_free} !== {1'b1, 4'd6, 2'd2, 1'b1}) begin
      errors++; $display("FAIL rr_mdu_wins got v=%b t=%0d s=%0d f=%b want 1 6 2 1", cdb_valid, cdb_tag, cdb_src, mdu_free);
    end
    tick();
    checks++;
    if ({cdb_valid, cdb_tag, cdb_src, add0_free} !== {1'b1, 4'd5, 2'd0, 1'b1}) begin
      errors++; $display("FAIL rr_add0_next got v=%b t=%0d s=%0d f=%b want 1 5 0 1", cdb_valid, cdb_tag, cdb_src, add0_free);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cdb_hold = 1'b1;
    add0_valid = 1'b1; add0_tag = 4'hA; add0_value = 32'hAAAA;
    add1_valid = 1'b1; add1_tag = 4'hB; add1_value = 32'hBBBB;
    mdu_valid  = 1'b1; mdu_tag  = 4'hC; mdu_value  = 32'hCCCC;
    tick();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    cdb_hold = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      checks++;
      if ({cdb_valid, mdu_free, add1_free, add0_free, mdu_ready, add1_ready, add0_ready} !== 7'b0000111) begin
        errors++;
        $display("FAIL reset_mid_%0d got v=%b free=%b%b%b rdy=%b%b%b want v=0 free=000 rdy=111",
                 n, cdb_valid, mdu_free, add1_free, add0_free, mdu_ready, add1_ready, add0_ready);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int t = 0; t < 9; t++) begin
      if (t < 8) begin
        add0_valid = 1'b1; add0_tag = 4'(t); add0_value = 32'(t * 3 + 1);
      end else begin
        idle_inputs();
      end
      tick();
      if (t >= 1) begin
        checks++;
        if ({cdb_valid, cdb_tag, cdb_value, add0_ready, err_overflow} !==
            {1'b1, 4'(t - 1), 32'((t - 1) * 3 + 1), 1'b1, 1'b0}) begin
          errors++;
          $display("FAIL b2b_%0d got v=%b t=%0d d=%0d rdy=%b err=%b want v=1 t=%0d d=%0d rdy=1 err=0",
                   t, cdb_valid, cdb_tag, cdb_value, add0_ready, err_overflow, t - 1, (t - 1) * 3 + 1);
        end
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      add0_valid = ($urandom_range(0, 99) < 45);
      add1_valid = ($urandom_range(0, 99) < 35);
      mdu_valid  = ($urandom_range(0, 99) < 25);
      add0_tag = 4'($urandom); add1_tag = 4'($urandom); mdu_tag = 4'($urandom);
      add0_value = $urandom; add1_value = $urandom; mdu_value = $urandom;
      cdb_hold = ($urandom_range(0, 99) < 20);
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL random_%0d got %h want %h", n, obs_vec(), exp_vec());
      end
    end
    idle_inputs();
    cdb_hold = 1'b0;
    for (int n = 0; n < 8; n++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL random_drain_%0d got %h want %h", n, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_three_sources();
    test_hold_overflow();
    test_rr_skip();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cdb_writeback.md
Name: cdb_writeback

Overview:
- Write-back end of the execution stage: collects completed results from the two add/sub units and the mul/div unit.
- Buffers those results per unit, then arbitrates them onto a single common data bus (CDB).
- Broadcasts one tag/value pair per cycle to the reservation stations and the register status table.
- Pulses a per-unit free signal so the dispatch logic can reuse that execution unit.

Parameters:
- DATA_W, 32, width of result value.
- TAG_W, 4, width of instruction/reservation-station tag.
- DEPTH, 2, entries per source buffer; power of 2, minimum 2.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- add0_valid  in  1  add/sub unit 0 result valid.
- add0_tag  in  TAG_W  tag of add0 result.
- add0_value  in  DATA_W  add0 result.
- add0_ready  out  1  add0 buffer can accept.
- add1_valid / add1_tag / add1_value / add1_ready  as add0, for add/sub unit 1.
- mdu_valid / mdu_tag / mdu_value / mdu_ready  as add0, for mul/div unit.
- cdb_hold  in  1  consumers stall; suppress broadcast this cycle.
- cdb_valid  out  1  broadcast valid, registered.
- cdb_tag  out  TAG_W  broadcast tag.
- cdb_value  out  DATA_W  broadcast value.
- cdb_src  out  2  source of broadcast: 0 add0, 1 add1, 2 mdu.
- add0_free, add1_free, mdu_free  out  1 each  one-cycle pulse, aligned with cdb_valid, for the broadcasting source.
- err_overflow  out  1  sticky; set when valid is asserted while ready is low.

Behaviour:
- Reset (rst_n low at edge):
  - All buffers empty; all *_ready = 1.
  - cdb_valid = 0, cdb_tag = 0, cdb_value = 0, cdb_src = 0.
  - All *_free = 0, err_overflow = 0.
  - Round-robin pointer = 0 (add0).
  - Reset mid-operation discards all buffered results without broadcasting them.
- Per-source buffer:
  - Circular FIFO of DEPTH entries, with read/write pointers wrapping modulo DEPTH and a count of 0..DEPTH.
  - *_ready = (count < DEPTH), driven combinationally from registered count. No same-cycle pass-through when full.
  - Push occurs when valid && ready at the edge.
  - Valid while not ready: data dropped, err_overflow set to 1 and held until reset.
  - Push and pop of the same buffer in the same cycle: count unchanged, both pointers advance.
- Arbitration (each edge, unless cdb_hold = 1):
  - Candidates are the non-empty buffers.
  - Grant goes to the first candidate at or after the RR pointer, in order add0 → add1 → mdu → wrap.
  - Grant pops that buffer's head; next cycle cdb_valid = 1 with the head tag/value, cdb_src = granted index, and that source's *_free = 1.
  - After a grant, RR pointer = granted index + 1, mod 3.
  - No candidates: cdb_valid = 0 and all *_free = 0; tag/value/src hold previous values; pointer unchanged.
- Hold:
  - cdb_hold = 1 at edge: no pop, cdb_valid = 0, *_free = 0, pointer unchanged.
  - Pushes are still accepted during hold.
- Latency:
  - Result accepted at edge N is visible on the CDB at N+1 at the earliest (empty buffers, no contention, no hold).
- Throughput: exactly one broadcast per non-held cycle while any buffer is non-empty.
- Ordering: results from the same source broadcast in arrival order. No ordering is guaranteed across sources.
- Unused encoding: cdb_src = 3 is never driven.

Test Plan:
- Reset, then add0 pushes tag 4'h3, value 32'd10 at edge 1 → edge 2: cdb_valid = 1, tag 3, value 10, src 0, add0_free = 1; edge 3: cdb_valid = 0.
- add0 (tag 1, value 5), add1 (tag 2, value 7), mdu (tag 3, value 35) all pushed at edge 1 → broadcasts at edges 2, 3, 4 in order tag 1, 2, 3; each *_free pulses once.
- mdu pushes tags 8, 9 on consecutive cycles with cdb_hold = 1 → mdu_ready = 0 after the second push. A third push with mdu_valid = 1 sets err_overflow = 1 and drops the data. Release hold → tags 8 then 9 broadcast; mdu_ready returns to 1 after the first pop.
- Pointer at add1, only add0 and mdu non-empty → mdu wins first, then add0.
- Buffers holding 3 results, rst_n low for one edge → cdb_valid = 0 for the following 3 cycles, all ready = 1, no stale broadcasts.
- Continuous add0 pushes every cycle (tags 0..7) → broadcasts every cycle from edge 2 onward, tags in order, count never exceeds 1, err_overflow stays 0.
